// File: rtl/rgmii_tx_frame_fifo.sv
// ---------------------------------------------------------------------------
// rgmii_tx_frame_fifo: store-and-forward TX frame buffer, host AXIS -> 8-bit MAC AXIS.
// Optional RGMII_TX_FIFO_STATS_EN adds frame/drop counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rgmii_tx_frame_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic                clk_int,
  input  logic                rst_int,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                frame_pending,
  output logic [ADDR_W:0]     fifo_level,
  output logic                drop_ovf,
  output logic                drop_bad
`ifdef RGMII_TX_FIFO_STATS_EN
  ,
  output logic [31:0]         tx_frame_cnt,
  output logic [31:0]         drop_cnt
`endif
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int WORD_W = DATA_W + KEEP_W + 1;
  localparam int IDX_W  = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_SER = 2'd2} rd_state_t;

  logic [WORD_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W:0] wr_ptr, wr_commit, rd_ptr, frame_cnt;
  logic            ready_q, drop_mode;
  logic            beat, is_full, dropping, commit, wr_en;

  rd_state_t         state, state_nxt;
  logic [WORD_W-1:0] nxt_word, cur_word;
  logic              nxt_valid, nxt_load, cur_take, readable;
  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] cur_data;
  logic [KEEP_W:0]   keep_ext;
  logic              cur_last, last_byte, frame_sent;
  logic [7:0]        byte_out;

  // ---------------- write side ----------------
  assign s_axis_tready = ready_q;
  assign beat     = s_axis_tvalid & ready_q;
  assign is_full  = (fifo_level == FULL_LVL);
  assign dropping = drop_mode | is_full;
  assign commit   = beat & s_axis_tlast & ~s_axis_tuser & ~dropping;
  assign wr_en    = beat & ~dropping & ~(s_axis_tlast & s_axis_tuser);

  always_ff @(posedge clk_int) begin
    if (wr_en)
      mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      ready_q   <= 1'b0;
      drop_mode <= 1'b0;
      drop_ovf  <= 1'b0;
      drop_bad  <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      ready_q  <= 1'b1;
      drop_ovf <= 1'b0;
      drop_bad <= 1'b0;
      if (beat) begin
        if (dropping) begin
          // Overflowed frame: swallow the remainder, rewind on its tlast.
          if (s_axis_tlast) begin
            wr_ptr    <= wr_commit;
            drop_mode <= 1'b0;
            drop_ovf  <= 1'b1;
          end else begin
            drop_mode <= 1'b1;
          end
        end else if (s_axis_tlast && s_axis_tuser) begin
          wr_ptr   <= wr_commit;
          drop_bad <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
          if (s_axis_tlast)
            wr_commit <= wr_ptr + (ADDR_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      frame_cnt <= '0;
    end else begin
      case ({commit, frame_sent})
        2'b10:   frame_cnt <= frame_cnt + (ADDR_W+1)'(1);
        2'b01:   frame_cnt <= frame_cnt - (ADDR_W+1)'(1);
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  assign fifo_level    = wr_ptr - rd_ptr;
  assign frame_pending = (frame_cnt != '0);

  // ---------------- read side ----------------
  // Only committed words are ever fetched, so drops never reach the reader.
  assign readable = (wr_commit != rd_ptr);
  assign cur_data = cur_word[DATA_W-1:0];
  assign keep_ext = {1'b0, cur_word[DATA_W +: KEEP_W]};
  assign cur_last = cur_word[WORD_W-1];

  always_comb begin
    byte_out  = '0;
    last_byte = 1'b0;
    for (int k = 0; k < KEEP_W; k++) begin
      if (byte_idx == k[IDX_W-1:0]) begin
        byte_out  = cur_data[k*8 +: 8];
        last_byte = keep_ext[k] & ~keep_ext[k+1];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cur_take  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (readable)
          state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        cur_take  = 1'b1;
        state_nxt = ST_SER;
      end
      ST_SER: begin
        if (m_axis_tready && last_byte) begin
          if (nxt_valid)
            cur_take = 1'b1;
          else if (readable)
            state_nxt = ST_FETCH;
          else
            state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The prefetch register refills while the current word is serialised.
  assign nxt_load = readable & (~nxt_valid | cur_take);

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      nxt_valid <= 1'b0;
      nxt_word  <= '0;
      cur_word  <= '0;
      byte_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (nxt_load) begin
        nxt_word  <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr    <= rd_ptr + (ADDR_W+1)'(1);
        nxt_valid <= 1'b1;
      end else if (cur_take) begin
        nxt_valid <= 1'b0;
      end
      if (cur_take) begin
        cur_word <= nxt_word;
        byte_idx <= '0;
      end else if (state == ST_SER && m_axis_tready && !last_byte) begin
        byte_idx <= byte_idx + IDX_W'(1);
      end
    end
  end

  assign m_axis_tvalid = (state == ST_SER);
  assign m_axis_tdata  = byte_out;
  assign m_axis_tlast  = (state == ST_SER) & last_byte & cur_last;
  assign m_axis_tuser  = 1'b0;
  assign frame_sent    = m_axis_tlast & m_axis_tready;

`ifdef RGMII_TX_FIFO_STATS_EN
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      tx_frame_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (frame_sent)
        tx_frame_cnt <= tx_frame_cnt + 32'd1;
      if (drop_ovf || drop_bad)
        drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgmii_tx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_rgmii_tx_frame_fifo: scoreboard bench, 32-bit/512-word and 8-bit/16-word instances.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rgmii_tx_frame_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  // Instance A: DATA_W=32, ADDR_W=9
  logic [31:0] a_s_tdata = '0;
  logic [3:0]  a_s_tkeep = '0;
  logic        a_s_tvalid = 1'b0, a_s_tlast = 1'b0, a_s_tuser = 1'b0;
  logic        a_s_tready;
  logic [7:0]  a_m_tdata;
  logic        a_m_tvalid, a_m_tlast, a_m_tuser;
  logic        a_m_tready = 1'b0;
  logic        a_pending, a_ovf, a_bad;
  logic [9:0]  a_level;

  // Instance B: DATA_W=8, ADDR_W=4
  logic [7:0]  b_s_tdata = '0;
  logic [0:0]  b_s_tkeep = '0;
  logic        b_s_tvalid = 1'b0, b_s_tlast = 1'b0, b_s_tuser = 1'b0;
  logic        b_s_tready;
  logic [7:0]  b_m_tdata;
  logic        b_m_tvalid, b_m_tlast, b_m_tuser;
  logic        b_m_tready = 1'b1;
  logic        b_pending, b_ovf, b_bad;
  logic [4:0]  b_level;

`ifdef RGMII_TX_FIFO_STATS_EN
  logic [31:0] a_txcnt, a_dropcnt, b_txcnt, b_dropcnt;
`endif

  rgmii_tx_frame_fifo #(.DATA_W(32), .ADDR_W(9)) u_dut_a (
    .clk_int(clk), .rst_int(rst),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tready(a_s_tready), .s_axis_tlast(a_s_tlast), .s_axis_tuser(a_s_tuser),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser),
    .frame_pending(a_pending), .fifo_level(a_level), .drop_ovf(a_ovf), .drop_bad(a_bad)
`ifdef RGMII_TX_FIFO_STATS_EN
    , .tx_frame_cnt(a_txcnt), .drop_cnt(a_dropcnt)
`endif
  );

  rgmii_tx_frame_fifo #(.DATA_W(8), .ADDR_W(4)) u_dut_b (
    .clk_int(clk), .rst_int(rst),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tuser(b_s_tuser),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
    .frame_pending(b_pending), .fifo_level(b_level), .drop_ovf(b_ovf), .drop_bad(b_bad)
`ifdef RGMII_TX_FIFO_STATS_EN
    , .tx_frame_cnt(b_txcnt), .drop_cnt(b_dropcnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] data; logic last; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // MAC ready pattern for A: 0 = always ready, 1 = toggle, 2 = never ready
  int a_rdy_mode = 0;
  initial forever begin
    @(posedge clk);
    #2;
    case (a_rdy_mode)
      0:       a_m_tready = 1'b1;
      1:       a_m_tready = ~a_m_tready;
      default: a_m_tready = 1'b0;
    endcase
  end

  // Output monitors: scoreboard pop, hold-while-stalled, no gaps inside a frame
  int   a_bytes = 0, a_tlasts = 0, a_bad_cnt = 0, a_ovf_cnt = 0;
  bit   a_in_frame = 0, a_stall = 0;
  logic [7:0] a_hold_d;
  logic a_hold_l;
  exp_t a_e;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      a_in_frame = 0;
      a_stall    = 0;
    end else begin
      if (a_in_frame) check("a_gap_in_frame", 32'(a_m_tvalid), 32'd1);
      if (a_stall) begin
        check("a_hold_data", 32'(a_m_tdata), 32'(a_hold_d));
        check("a_hold_last", 32'(a_m_tlast), 32'(a_hold_l));
      end
      if (a_m_tvalid && a_m_tready) begin
        if (qa.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_unexpected_byte: got %0h expected none", a_m_tdata);
        end else begin
          a_e = qa.pop_front();
          check("a_data", 32'(a_m_tdata), 32'(a_e.data));
          check("a_last", 32'(a_m_tlast), 32'(a_e.last));
        end
        a_bytes++;
        if (a_m_tlast) a_tlasts++;
        a_in_frame = !a_m_tlast;
      end
      a_stall  = a_m_tvalid && !a_m_tready;
      a_hold_d = a_m_tdata;
      a_hold_l = a_m_tlast;
      if (a_bad) a_bad_cnt++;
      if (a_ovf) a_ovf_cnt++;
    end
  end

  int   b_bytes = 0, b_tlasts = 0, b_ovf_cnt = 0;
  bit   b_in_frame = 0;
  exp_t b_e;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      b_in_frame = 0;
    end else begin
      if (b_in_frame) check("b_gap_in_frame", 32'(b_m_tvalid), 32'd1);
      if (b_m_tvalid && b_m_tready) begin
        if (qb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected_byte: got %0h expected none", b_m_tdata);
        end else begin
          b_e = qb.pop_front();
          check("b_data", 32'(b_m_tdata), 32'(b_e.data));
          check("b_last", 32'(b_m_tlast), 32'(b_e.last));
        end
        b_bytes++;
        if (b_m_tlast) b_tlasts++;
        b_in_frame = !b_m_tlast;
      end
      if (b_ovf) b_ovf_cnt++;
    end
  end

  task automatic send_a(int nbytes, bit bad, logic [7:0] base);
    int nbeats = (nbytes + 3) / 4;
    for (int i = 0; i < nbeats; i++) begin
      int rem = nbytes - i*4;
      int nk  = (rem > 4) ? 4 : rem;
      bit lst = (i == nbeats - 1);
      logic [31:0] d;
      for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(int'(base) + i*4 + j);
      a_s_tdata  = d;
      a_s_tkeep  = 4'((1 << nk) - 1);
      a_s_tlast  = lst;
      a_s_tuser  = bad && lst;
      a_s_tvalid = 1'b1;
      if (!bad)
        for (int j = 0; j < nk; j++)
          qa.push_back('{data: 8'(int'(base) + i*4 + j), last: lst && (j == nk - 1)});
      check("a_s_tready", 32'(a_s_tready), 32'd1);
      @(posedge clk); #1;
    end
    a_s_tvalid = 1'b0;
    a_s_tlast  = 1'b0;
    a_s_tuser  = 1'b0;
  endtask

  task automatic send_b(int nbytes, logic [7:0] base, bit expect_out);
    for (int i = 0; i < nbytes; i++) begin
      b_s_tdata  = 8'(int'(base) + i);
      b_s_tkeep  = 1'b1;
      b_s_tlast  = (i == nbytes - 1);
      b_s_tvalid = 1'b1;
      if (expect_out) qb.push_back('{data: 8'(int'(base) + i), last: (i == nbytes - 1)});
      check("b_s_tready", 32'(b_s_tready), 32'd1);
      @(posedge clk); #1;
    end
    b_s_tvalid = 1'b0;
    b_s_tlast  = 1'b0;
  endtask

  task automatic drain_a(string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (qa.size() == 0 && !a_m_tvalid) break;
    end
    check({name, "_queue_empty"}, 32'(qa.size()), 32'd0);
    check({name, "_level"}, 32'(a_level), 32'd0);
    check({name, "_pending"}, 32'(a_pending), 32'd0);
  endtask

  typedef struct {
    int nbytes; bit bad; bit toggle; bit drain; bit lat;
    int exp_frames; int exp_bad;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{60, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0};  // full last word, latency check
    vecs[1] = '{61, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0};  // last keep 0001
    vecs[2] = '{37, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1};  // bad frame, good one right behind
    vecs[3] = '{64, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1};
    vecs[4] = '{64, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1};  // back-to-back under stalls
    vecs[5] = '{64, 1'b0, 1'b1, 1'b1, 1'b0, 5, 1};
    vecs[6] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 6, 1};  // single-byte frame
    vecs[7] = '{7,  1'b0, 1'b1, 1'b1, 1'b0, 7, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_s_tready", 32'(a_s_tready), 32'd0);
    check("rst_a_m_tvalid", 32'(a_m_tvalid), 32'd0);
    check("rst_a_m_tlast",  32'(a_m_tlast),  32'd0);
    check("rst_a_pending",  32'(a_pending),  32'd0);
    check("rst_a_level",    32'(a_level),    32'd0);
    check("rst_a_pulses",   32'({a_ovf, a_bad}), 32'd0);
    check("rst_b_s_tready", 32'(b_s_tready), 32'd0);
    check("rst_b_m_tvalid", 32'(b_m_tvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_a_tready", 32'(a_s_tready), 32'd1);
    check("post_rst_b_tready", 32'(b_s_tready), 32'd1);
    check("a_m_tuser", 32'(a_m_tuser), 32'd0);

    // Instance B: oversize frame drops whole, next full-depth frame goes through
    send_b(20, 8'h30, 1'b0);
    repeat (5) @(negedge clk);
    check("b_ovf_pulses", 32'(b_ovf_cnt), 32'd1);
    check("b_no_output", 32'(b_bytes), 32'd0);
    check("b_level_after_drop", 32'(b_level), 32'd0);
`ifdef RGMII_TX_FIFO_STATS_EN
    check("b_drop_cnt", b_dropcnt, 32'd1);
`endif
    send_b(16, 8'hc0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (qb.size() == 0 && !b_m_tvalid) break;
    end
    check("b_queue_empty", 32'(qb.size()), 32'd0);
    check("b_tlasts", 32'(b_tlasts), 32'd1);
    check("b_level_final", 32'(b_level), 32'd0);

    // Instance A: table-driven frames
    for (int v = 0; v < 8; v++) begin
      a_rdy_mode = vecs[v].toggle ? 1 : 0;
      send_a(vecs[v].nbytes, vecs[v].bad, 8'(v*16 + 3));
      if (vecs[v].lat) begin
        @(negedge clk); check("lat_cycle0", 32'(a_m_tvalid), 32'd0);
        @(negedge clk); check("lat_cycle1", 32'(a_m_tvalid), 32'd0);
        @(negedge clk); check("lat_cycle2", 32'(a_m_tvalid), 32'd1);
      end
      if (vecs[v].drain) begin
        drain_a($sformatf("vec%0d", v));
        check($sformatf("vec%0d_tlasts", v), 32'(a_tlasts), 32'(vecs[v].exp_frames));
        check($sformatf("vec%0d_drop_bad", v), 32'(a_bad_cnt), 32'(vecs[v].exp_bad));
`ifdef RGMII_TX_FIFO_STATS_EN
        check($sformatf("vec%0d_tx_frame_cnt", v), a_txcnt, 32'(vecs[v].exp_frames));
        check($sformatf("vec%0d_drop_cnt", v), a_dropcnt, 32'(vecs[v].exp_bad));
`endif
      end
    end
    check("a_no_ovf", 32'(a_ovf_cnt), 32'd0);

    // Reset in the middle of serialisation
    begin
      int start = a_bytes;
      int tl0;
      a_rdy_mode = 1;
      send_a(64, 1'b0, 8'h80);
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (a_bytes >= start + 10) break;
      end
      check("mid_rst_progress", 32'(a_bytes >= start + 10), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      a_rdy_mode = 2;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_tvalid",  32'(a_m_tvalid), 32'd0);
      check("mid_rst_tlast",   32'(a_m_tlast),  32'd0);
      check("mid_rst_pending", 32'(a_pending),  32'd0);
      check("mid_rst_level",   32'(a_level),    32'd0);
      check("mid_rst_tready",  32'(a_s_tready), 32'd0);
      qa.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      a_rdy_mode = 0;
      @(posedge clk); #1;
      check("after_rst_tready", 32'(a_s_tready), 32'd1);
      repeat (5) @(negedge clk);
      check("after_rst_idle", 32'(a_m_tvalid), 32'd0);
      tl0 = a_tlasts;
      send_a(60, 1'b0, 8'h5a);
      drain_a("after_rst");
      check("after_rst_tlasts", 32'(a_tlasts - tl0), 32'd1);
`ifdef RGMII_TX_FIFO_STATS_EN
      check("after_rst_tx_frame_cnt", a_txcnt, 32'd1);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
